// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the per-digit load clamp.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Limit a raw nibble to a legal BCD digit, so non-decimal values never enter the counter.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: resets to 9, loads a clamped value,
// and decrements with 0 -> 9 wrap when told to by the cascade logic.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dec_in,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t digit,
    output logic       is_zero
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // Next digit: load wins over decrement; a decrement from zero wraps to nine.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_digit);
        end else if (dec_in) begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : (digit_q - 4'd1);
        end
    end

    // Digit register; reset forces nine immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= BCD_MAX;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit   = digit_q;
    assign is_zero = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit loadable BCD down-counter with borrow cascade.
// Optional macro BCD_DOWN_SAT_EN: saturate at all-zero instead of wrapping to all-nine.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  zero,
    output logic                  borrow
);

    logic [DIGITS-1:0] dec_in;
    logic [DIGITS-1:0] is_zero;
    logic              step_c;

    assign zero   = &is_zero;
    assign borrow = en && !load && zero;

`ifdef BCD_DOWN_SAT_EN
    // Counting stops at all-zero; only load or reset moves the counter off zero.
    assign step_c = en && !load && !zero;
`else
    // All-zero simply wraps to all-nine through the normal cascade.
    assign step_c = en && !load;
`endif

    // Digit i steps only when every lower digit is zero.
    always_comb begin : dec_chain
        logic lower_zero;
        dec_in     = '0;
        lower_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dec_in[i]  = step_c && lower_zero;
            lower_zero = lower_zero && is_zero[i];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset_n    (reset_n),
            .dec_in     (dec_in[g]),
            .load       (load),
            .load_digit (load_val[4*g +: 4]),
            .digit      (q[4*g +: 4]),
            .is_zero    (is_zero[g])
        );
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed and randomized checks of the 2-digit BCD down-counter.
module tb_bcd_down_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q;
    logic       zero;
    logic       borrow;

    int vectors     = 0;
    int miscompares = 0;

`ifdef BCD_DOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .zero     (zero),
        .borrow   (borrow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_q,
                       input logic exp_z, input logic exp_b);
        vectors++;
        assert (q === exp_q) else begin
            miscompares++;
            $error("FAIL %s q observed %h expected %h", tag, q, exp_q);
        end
        vectors++;
        assert (zero === exp_z) else begin
            miscompares++;
            $error("FAIL %s zero observed %b expected %b", tag, zero, exp_z);
        end
        vectors++;
        assert (borrow === exp_b) else begin
            miscompares++;
            $error("FAIL %s borrow observed %b expected %b", tag, borrow, exp_b);
        end
    endtask

    function automatic int clamp_dec(input logic [7:0] v);
        int t;
        int o;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int m);
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    initial begin
        int   m;
        logic p_en;
        logic p_load;
        logic [7:0] p_val;

        reset_n = 1'b0; en = 1'b0; load = 1'b0; load_val = 8'h00;
        #12;
        chk("reset", 8'h99, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        en = 1'b1;
        #1;
        chk("post_release", 8'h99, 1'b0, 1'b0);

        // Plain counting from 99.
        tick(); chk("cnt1", 8'h98, 1'b0, 1'b0);
        tick(); chk("cnt2", 8'h97, 1'b0, 1'b0);
        tick(); chk("cnt3", 8'h96, 1'b0, 1'b0);

        // Load 10 then cascade borrow into the tens digit.
        en = 1'b0; load = 1'b1; load_val = 8'h10;
        tick(); chk("load10", 8'h10, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk("hold10", 8'h10, 1'b0, 1'b0);
        en = 1'b1;
        tick(); chk("cascade09", 8'h09, 1'b0, 1'b0);
        tick(); chk("dec08", 8'h08, 1'b0, 1'b0);

        // Load 01 with en high, count into zero and beyond.
        load = 1'b1; load_val = 8'h01;
        tick(); chk("load01", 8'h01, 1'b0, 1'b0);
        load = 1'b0;
        #1; chk("at01", 8'h01, 1'b0, 1'b0);
        tick(); chk("at00", 8'h00, 1'b1, 1'b1);
        tick();
        if (SAT) chk("sat_hold", 8'h00, 1'b1, 1'b1);
        else     chk("wrap99", 8'h99, 1'b0, 1'b0);
        tick();
        if (SAT) chk("sat_hold2", 8'h00, 1'b1, 1'b1);
        else     chk("after_wrap", 8'h98, 1'b0, 1'b0);

        // Zero with en low, then load pending while at zero suppresses borrow.
        en = 1'b0; load = 1'b1; load_val = 8'h00;
        tick(); chk("zero_idle", 8'h00, 1'b1, 1'b0);
        en = 1'b1; load_val = 8'hA3;
        #1; chk("zero_load_pending", 8'h00, 1'b1, 1'b0);

        // Load beats en, with per-digit clamp.
        tick(); chk("clampA3", 8'h93, 1'b0, 1'b0);
        load_val = 8'hFF;
        tick(); chk("clampFF", 8'h99, 1'b0, 1'b0);
        load_val = 8'h5C;
        tick(); chk("clamp5C", 8'h59, 1'b0, 1'b0);

        // Reach 45, then reset asynchronously mid-cycle.
        load_val = 8'h47;
        tick(); chk("load47", 8'h47, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk("dec46", 8'h46, 1'b0, 1'b0);
        tick(); chk("dec45", 8'h45, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1; chk("async_reset", 8'h99, 1'b0, 1'b0);
        load = 1'b1; load_val = 8'h12;
        tick(); chk("reset_over_load", 8'h99, 1'b0, 1'b0);
        load = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick(); chk("first_after_reset", 8'h98, 1'b0, 1'b0);

        // Randomized traffic against an integer model.
        m = 98;
        for (int c = 0; c < 400; c++) begin
            p_en   = 1'($urandom_range(0, 3) != 0);
            p_load = 1'($urandom_range(0, 7) == 0);
            p_val  = 8'($urandom);
            en = p_en; load = p_load; load_val = p_val;
            if (reset_n && $urandom_range(0, 31) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            if (!reset_n) m = 99;
            #1;
            chk("rand_comb", to_bcd(m), 1'(m == 0), 1'(p_en && !p_load && m == 0));
            @(posedge clk);
            if (!reset_n)    m = 99;
            else if (p_load) m = clamp_dec(p_val);
            else if (p_en)   m = (m == 0) ? (SAT ? 0 : 99) : m - 1;
            #1;
            chk("rand_seq", to_bcd(m), 1'(m == 0), 1'(p_en && !p_load && m == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
